instr_readback_checker: RTL and testbench
=========================================

INSTR_READBACK_CHECKER -- requirements
Module: instr_readback_checker

Interface
REQ-001 Parameters SHALL be: ADDR_W, 5, register-file index width; OPD_W, 32, signed operand width; RES_W, 64, signed result width.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  sweep request, sampled only in IDLE.
REQ-005 first_ptr  in  ADDR_W  first entry index of the sweep.
REQ-006 last_ptr  in  ADDR_W  last entry index of the sweep.
REQ-007 read_pointer  out  ADDR_W  index presented to the instruction register read port.
REQ-008 iw_opcode  in  4  opcode of the returned word: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
REQ-009 iw_operand_a  in  OPD_W  returned operand_a, signed.
REQ-010 iw_operand_b  in  OPD_W  returned operand_b, signed.
REQ-011 iw_result  in  RES_W  returned stored result, signed.
REQ-012 busy  out  1  high while a sweep is in progress.
REQ-013 done  out  1  one-cycle pulse when a sweep completes.
REQ-014 err_valid  out  1  one-cycle pulse per mismatching entry.
REQ-015 err_index  out  ADDR_W  entry index of the current mismatch; held until the next mismatch.
REQ-016 exp_result  out  RES_W  expected result of the current mismatch; held until the next mismatch.
REQ-017 pass_count, fail_count, skip_count  out  6 each  per-sweep tallies.

Function
REQ-018 The FSM SHALL have states IDLE, SWEEP, DRAIN and DONE.
REQ-019 In IDLE, start=1 SHALL transition to SWEEP, clear all three counts, load read_pointer=first_ptr, and set N=((last_ptr-first_ptr) mod 32)+1 (range 1..32).
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 In SWEEP, read_pointer SHALL advance by 1 per cycle, wrapping 31->0, until N pointers have been issued, then transition to DRAIN.
REQ-022 Read latency is one cycle: the word for the pointer driven in cycle k SHALL be checked at the end of cycle k+1, giving one entry checked per cycle with no bubbles.
REQ-023 DRAIN SHALL last exactly one cycle to check the last entry, then transition to DONE.
REQ-024 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-025 busy SHALL be 1 in SWEEP and DRAIN, and 0 in IDLE and DONE.
REQ-026 The expected result SHALL be computed from the returned operands, sign-extended to RES_W:
- ZERO -> 0
- PASSA -> a
- PASSB -> b
- ADD -> a+b (33-bit exact)
- SUB -> a-b
- MULT -> full 64-bit signed product
- DIV -> a/b, truncated toward zero
- MOD -> a%b, sign of a
REQ-027 DIV or MOD with operand_b=0 SHALL increment skip_count only, with no err_valid.
REQ-028 An opcode of 8..15 SHALL be counted as a failure, with exp_result=0.
REQ-029 A checked entry with iw_result equal to the expected result SHALL increment pass_count; otherwise it SHALL increment fail_count and pulse err_valid in the same cycle the counter updates.
REQ-030 After done, pass_count+fail_count+skip_count SHALL equal N, and the counts SHALL hold until the next accepted start.

Reset
REQ-031 When reset=1 at a clock edge, the following SHALL hold in the next cycle: state=IDLE, read_pointer=0, busy=0, done=0, err_valid=0, err_index=0, exp_result=0, and all counts=0.
REQ-032 Reset during SWEEP or DRAIN SHALL abort the sweep with no done pulse; reset SHALL take priority over start in the same cycle.

Verification
REQ-033 Entries 0..3 are preloaded with correct ADD/SUB/MULT/PASSA; start with first=0, last=3 -> read_pointer 0,1,2,3 on consecutive cycles, done 6 cycles after start, pass=4, fail=0.
REQ-034 Entry 5 is MULT a=-3, b=7 with stored result 0; sweep 5..5 -> err_valid once, err_index=5, exp_result=-21, fail=1, N=1.
REQ-035 Wrap sweep with first=30, last=1 -> read_pointer 30,31,0,1 and counts total 4.
REQ-036 Entry 2 is DIV with b=0 and entry 3 is opcode 9 -> skip=1, fail=1, err_valid pulses only for index 3.
REQ-037 Reset asserted in the 2nd SWEEP cycle of a 0..31 sweep -> next cycle busy=0 and counts=0, with no done pulse; start pulsed while busy is ignored.
REQ-038 first=last=0 -> N=1; a full 0..31 sweep -> N=32 and the counts total 32.

Source files
------------

// File: rtl/instr_readback_checker.sv
// Instruction register read-back checker.
// Sweeps a range of register-file entries through a one-cycle-latency read
// port, recomputes each entry's result from its operands and opcode, and
// tallies pass / fail / skip outcomes. Mismatches are reported one at a time.
module instr_readback_checker #(
    parameter int ADDR_W = 5,
    parameter int OPD_W  = 32,
    parameter int RES_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_ptr,
    input  logic [ADDR_W-1:0] last_ptr,
    output logic [ADDR_W-1:0] read_pointer,
    input  logic [3:0]        iw_opcode,
    input  logic [OPD_W-1:0]  iw_operand_a,
    input  logic [OPD_W-1:0]  iw_operand_b,
    input  logic [RES_W-1:0]  iw_result,
    output logic              busy,
    output logic              done,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_index,
    output logic [RES_W-1:0]  exp_result,
    output logic [5:0]        pass_count,
    output logic [5:0]        fail_count,
    output logic [5:0]        skip_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    state_t state;
    state_t next_state;

    // Pointers still to be issued in the current sweep (1..2**ADDR_W).
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W:0]   sweep_len;

    // One-cycle delayed copy of the issued pointer: the returned word is
    // checked in the cycle after its pointer was driven.
    logic              chk_valid;
    logic [ADDR_W-1:0] chk_index;

    // Operands sign-extended to the result width, plus the expected result.
    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] b_safe;
    logic signed [RES_W-1:0] expected;
    logic                    b_zero;
    logic                    is_skip;
    logic                    op_illegal;
    logic                    mismatch;

    // Range length wraps modulo the register-file size, so last < first is a
    // wrapping sweep and first == last is a single entry.
    assign span      = last_ptr - first_ptr;
    assign sweep_len = {1'b0, span} + (ADDR_W+1)'(1);

    assign a_ext  = RES_W'($signed(iw_operand_a));
    assign b_ext  = RES_W'($signed(iw_operand_b));
    assign b_zero = (iw_operand_b == '0);
    // Divisor forced non-zero so the divider never sees 0; those entries are
    // skipped anyway.
    assign b_safe = b_zero ? RES_W'(1) : b_ext;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and state-decoded outputs.
    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = SWEEP;
            end
            SWEEP: begin
                busy = 1'b1;
                if (remaining == (ADDR_W+1)'(1)) next_state = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Read pointer issue and the one-cycle check pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_pointer <= '0;
            remaining    <= '0;
            chk_valid    <= 1'b0;
            chk_index    <= '0;
        end else begin
            chk_valid <= (state == SWEEP);
            chk_index <= read_pointer;
            if (state == IDLE && start) begin
                read_pointer <= first_ptr;
                remaining    <= sweep_len;
            end else if (state == SWEEP) begin
                read_pointer <= read_pointer + ADDR_W'(1);
                remaining    <= remaining - (ADDR_W+1)'(1);
            end
        end
    end

    // Expected result of the returned word; classifies skips and bad opcodes.
    always_comb begin
        expected   = '0;
        is_skip    = 1'b0;
        op_illegal = 1'b0;
        case (iw_opcode)
            OP_ZERO:  expected = '0;
            OP_PASSA: expected = a_ext;
            OP_PASSB: expected = b_ext;
            OP_ADD:   expected = a_ext + b_ext;
            OP_SUB:   expected = a_ext - b_ext;
            OP_MULT:  expected = a_ext * b_ext;
            OP_DIV: begin
                is_skip  = b_zero;
                expected = a_ext / b_safe;
            end
            OP_MOD: begin
                is_skip  = b_zero;
                expected = a_ext % b_safe;
            end
            default: begin
                op_illegal = 1'b1;
                expected   = '0;
            end
        endcase
    end

    assign mismatch = op_illegal || (iw_result != expected);

    // Tallies and mismatch reporting; err_valid rises with the fail_count bump.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_count <= '0;
            fail_count <= '0;
            skip_count <= '0;
            err_valid  <= 1'b0;
            err_index  <= '0;
            exp_result <= '0;
        end else begin
            err_valid <= 1'b0;
            if (state == IDLE && start) begin
                pass_count <= '0;
                fail_count <= '0;
                skip_count <= '0;
            end else if (chk_valid) begin
                if (is_skip) begin
                    skip_count <= skip_count + 6'd1;
                end else if (mismatch) begin
                    fail_count <= fail_count + 6'd1;
                    err_valid  <= 1'b1;
                    err_index  <= chk_index;
                    exp_result <= expected;
                end else begin
                    pass_count <= pass_count + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_readback_checker.sv
// Bench for instr_readback_checker: a synchronous-read register file model,
// a reference model that predicts per-sweep outcomes, and a monitor that
// compares DUT reports against the predictions queued at each start.
module tb_instr_readback_checker;

    localparam int ADDR_W = 5;
    localparam int OPD_W  = 32;
    localparam int RES_W  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] first_ptr;
    logic [ADDR_W-1:0] last_ptr;
    logic [ADDR_W-1:0] read_pointer;
    logic [3:0]        iw_opcode;
    logic [OPD_W-1:0]  iw_operand_a;
    logic [OPD_W-1:0]  iw_operand_b;
    logic [RES_W-1:0]  iw_result;
    logic              busy;
    logic              done;
    logic              err_valid;
    logic [ADDR_W-1:0] err_index;
    logic [RES_W-1:0]  exp_result;
    logic [5:0]        pass_count;
    logic [5:0]        fail_count;
    logic [5:0]        skip_count;

    always #5 clk = ~clk;

    instr_readback_checker #(.ADDR_W(ADDR_W), .OPD_W(OPD_W), .RES_W(RES_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .first_ptr    (first_ptr),
        .last_ptr     (last_ptr),
        .read_pointer (read_pointer),
        .iw_opcode    (iw_opcode),
        .iw_operand_a (iw_operand_a),
        .iw_operand_b (iw_operand_b),
        .iw_result    (iw_result),
        .busy         (busy),
        .done         (done),
        .err_valid    (err_valid),
        .err_index    (err_index),
        .exp_result   (exp_result),
        .pass_count   (pass_count),
        .fail_count   (fail_count),
        .skip_count   (skip_count)
    );

    typedef struct {
        logic [3:0] op;
        int         a;
        int         b;
        longint     res;
    } entry_t;

    typedef struct {
        int     idx;
        longint exp;
    } err_t;

    typedef struct {
        int p;
        int f;
        int s;
    } tally_t;

    entry_t mem [32];
    err_t   err_q[$];
    tally_t done_q[$];
    err_t   mon_e;
    tally_t mon_t;

    int checks = 0;
    int errors = 0;

    // Register file with one-cycle read latency.
    always @(posedge clk) begin
        iw_opcode    <= mem[read_pointer].op;
        iw_operand_a <= mem[read_pointer].a;
        iw_operand_b <= mem[read_pointer].b;
        iw_result    <= mem[read_pointer].res;
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Outcome of one entry: kind 0 = pass, 1 = fail, 2 = skip.
    function automatic void ref_eval(input entry_t e, output int kind, output longint exp);
        longint a = e.a;
        longint b = e.b;
        kind = 0;
        exp  = 0;
        case (e.op)
            4'd0: exp = 0;
            4'd1: exp = a;
            4'd2: exp = b;
            4'd3: exp = a + b;
            4'd4: exp = a - b;
            4'd5: exp = a * b;
            4'd6: if (b == 0) kind = 2; else exp = a / b;
            4'd7: if (b == 0) kind = 2; else exp = a % b;
            default: kind = 1;
        endcase
        if (kind == 0 && e.res != exp) kind = 1;
    endfunction

    function automatic int rand_opd();
        if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, 40)) - 20;
        return int'($urandom);
    endfunction

    function automatic entry_t rand_entry();
        entry_t e;
        int     kind;
        longint exp;
        int     r = int'($urandom_range(0, 19));
        e.op = (r < 16) ? 4'(r % 8) : 4'(8 + $urandom_range(0, 7));
        e.a  = rand_opd();
        e.b  = rand_opd();
        if ((e.op == 4'd6 || e.op == 4'd7) && $urandom_range(0, 4) == 0) e.b = 0;
        e.res = 0;
        ref_eval(e, kind, exp);
        if (e.op > 4'd7 || kind == 2) e.res = {$urandom, $urandom};
        else if ($urandom_range(0, 3) == 0) e.res = exp ^ (longint'(1) << $urandom_range(0, 63));
        else e.res = exp;
        return e;
    endfunction

    // Monitor: every err_valid and done pulse must match the next prediction.
    always @(negedge clk) begin
        if (!reset) begin
            if (err_valid) begin
                check("err_valid expected", longint'(err_q.size() > 0), 1);
                if (err_q.size() > 0) begin
                    mon_e = err_q.pop_front();
                    check("err_index", err_index, mon_e.idx);
                    check("exp_result", exp_result, mon_e.exp);
                end
            end
            if (done) begin
                check("done expected", longint'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    mon_t = done_q.pop_front();
                    check("pass_count", pass_count, mon_t.p);
                    check("fail_count", fail_count, mon_t.f);
                    check("skip_count", skip_count, mon_t.s);
                    check("errors pending at done", err_q.size(), 0);
                end
            end
        end
    end

    task automatic run_sweep(input int first, input int last, input bit poke_start);
        int     n = ((last - first) & 31) + 1;
        int     idx;
        int     kind;
        longint exp;
        tally_t t = '{0, 0, 0};
        int     cyc;
        for (int i = 0; i < n; i++) begin
            idx = (first + i) & 31;
            ref_eval(mem[idx], kind, exp);
            if (kind == 0) t.p++;
            else if (kind == 2) t.s++;
            else begin
                t.f++;
                err_q.push_back('{idx, exp});
            end
        end
        done_q.push_back(t);
        @(negedge clk);
        first_ptr = ADDR_W'(first);
        last_ptr  = ADDR_W'(last);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy in sweep", busy, 1);
        check("read_pointer first", read_pointer, first);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            if (poke_start) begin
                start     = $urandom_range(0, 1) == 1;
                first_ptr = ADDR_W'($urandom);
                last_ptr  = ADDR_W'($urandom);
            end
            check("read_pointer", read_pointer, (first + i) & 31);
        end
        start = 1'b0;
        cyc = n;
        while (!done && cyc < n + 8) begin
            @(negedge clk);
            cyc++;
        end
        check("done latency", cyc, n + 2);
        check("busy at done", busy, 0);
        @(negedge clk);
        check("done one cycle", done, 0);
        check("total held", pass_count + fail_count + skip_count, n);
        check("pass held", pass_count, t.p);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        first_ptr = '0;
        last_ptr  = '0;
        for (int i = 0; i < 32; i++) mem[i] = '{4'd0, 0, 0, 0};
        repeat (2) @(negedge clk);
        check("reset read_pointer", read_pointer, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err_valid", err_valid, 0);
        check("reset counts", pass_count + fail_count + skip_count, 0);
        reset = 1'b0;

        // Four correct entries.
        mem[0] = '{4'd3, 100, -30, 70};
        mem[1] = '{4'd4, 5, 9, -4};
        mem[2] = '{4'd5, -70000, 70000, -64'sd4900000000};
        mem[3] = '{4'd1, -123, 55, -123};
        run_sweep(0, 3, 1'b0);
        check("directed pass", pass_count, 4);
        check("directed fail", fail_count, 0);

        // Single bad MULT entry.
        mem[5] = '{4'd5, -3, 7, 0};
        run_sweep(5, 5, 1'b0);
        check("mult err_index", err_index, 5);
        check("mult exp_result", exp_result, -21);
        check("mult fail", fail_count, 1);

        // Abort a full sweep with reset in its 2nd cycle; start competes.
        @(negedge clk);
        first_ptr = 5'd0;
        last_ptr  = 5'd31;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("abort busy", busy, 0);
        check("abort counts", pass_count + fail_count + skip_count, 0);
        check("abort read_pointer", read_pointer, 0);
        check("abort err_index", err_index, 0);
        check("abort exp_result", exp_result, 0);
        repeat (40) @(negedge clk);
        check("abort no done", done, 0);

        // Divide by zero is skipped, illegal opcode fails.
        mem[2] = '{4'd6, 8, 0, 0};
        mem[3] = '{4'd9, 1, 2, 0};
        run_sweep(2, 3, 1'b0);
        check("skip count", skip_count, 1);
        check("illegal fail", fail_count, 1);
        check("illegal err_index", err_index, 3);

        // Wrap, single-entry and full sweeps over random contents.
        for (int i = 0; i < 32; i++) mem[i] = rand_entry();
        run_sweep(30, 1, 1'b0);
        run_sweep(0, 0, 1'b0);
        run_sweep(0, 31, 1'b1);
        check("full total", pass_count + fail_count + skip_count, 32);

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 32; i++) mem[i] = rand_entry();
            run_sweep(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), k[0]);
        end

        repeat (4) @(negedge clk);
        check("err queue drained", err_q.size(), 0);
        check("done queue drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
